// File: rtl/uart_tx.sv
// Transmit-only 8N1 UART: 4-entry byte FIFO behind a valid/ready write port,
// serialised LSB first on txd at divide_count clocks per bit.
module uart_tx #(
  parameter int divide_count = 712
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       busy
);
  localparam logic [9:0] div_last = 10'(divide_count);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t     state;
  logic [7:0] fifo [4];
  logic [1:0] rd_ptr;
  logic [1:0] wr_ptr;
  logic [2:0] count;
  logic [2:0] count_next;
  logic [7:0] shifter;
  logic [2:0] bit_count;
  logic [9:0] divider;
  logic       push;
  logic       pop;
  logic       bit_end;
  logic       to_idle;

  // Pops only happen where a new frame can begin: from IDLE, or at the end of a stop bit.
  always_comb begin
    bit_end    = (state != IDLE) && (divider == div_last);
    push       = tx_valid && (count != 3'd4);
    pop        = (count != 3'd0) && ((state == IDLE) || ((state == STOP) && bit_end));
    count_next = count + {2'b00, push} - {2'b00, pop};
    to_idle    = ((state == IDLE) || ((state == STOP) && bit_end)) && !pop;
  end

  assign tx_ready = (count != 3'd4);

  always_ff @(posedge clock) begin
    if (push) fifo[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rd_ptr    <= 2'd0;
      wr_ptr    <= 2'd0;
      count     <= 3'd0;
      shifter   <= 8'd0;
      bit_count <= 3'd0;
      divider   <= 10'd0;
      txd       <= 1'b1;
      busy      <= 1'b0;
    end else begin
      count <= count_next;
      busy  <= !to_idle || (count_next != 3'd0);
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;

      case (state)
        IDLE: begin
          txd     <= 1'b1;
          divider <= 10'd0;
          if (pop) begin
            shifter   <= fifo[rd_ptr];
            bit_count <= 3'd0;
            divider   <= 10'd1;
            txd       <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (bit_end) begin
            divider <= 10'd1;
            txd     <= shifter[0];
            state   <= DATA;
          end else begin
            divider <= divider + 10'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            divider <= 10'd1;
            shifter <= shifter >> 1;
            if (bit_count == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              bit_count <= bit_count + 3'd1;
              txd       <= shifter[1];
            end
          end else begin
            divider <= divider + 10'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            // Next frame's start bit begins on this same edge, no idle bit in between.
            if (pop) begin
              shifter   <= fifo[rd_ptr];
              bit_count <= 3'd0;
              divider   <= 10'd1;
              txd       <= 1'b0;
              state     <= START;
            end else begin
              divider <= 10'd0;
              txd     <= 1'b1;
              state   <= IDLE;
            end
          end else begin
            divider <= divider + 10'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: accepted bytes queue their expected 40-clock
// frame (divide_count = 4); a monitor captures frames from txd and compares.
module tb_uart_tx;
  logic       clock;
  logic       reset;
  logic [7:0] tx_data4, tx_data1;
  logic       tx_valid4, tx_valid1;
  logic       tx_ready4, tx_ready1;
  logic       txd4, txd1;
  logic       busy4, busy1;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];

  uart_tx #(.divide_count(4)) dut4 (
    .clock(clock), .reset(reset), .tx_data(tx_data4), .tx_valid(tx_valid4),
    .tx_ready(tx_ready4), .txd(txd4), .busy(busy4)
  );

  uart_tx #(.divide_count(1)) dut1 (
    .clock(clock), .reset(reset), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .txd(txd1), .busy(busy1)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line level for each of the 40 clocks of a frame: start 0, data LSB first, stop 1.
  function automatic logic [39:0] frame4(input logic [7:0] b);
    logic [39:0] f;
    f = '0;
    for (int i = 0; i < 40; i++) begin
      if (i < 4)       f[i] = 1'b0;
      else if (i < 36) f[i] = b[(i - 4) / 4];
      else             f[i] = 1'b1;
    end
    return f;
  endfunction

  initial begin : monitor
    logic [39:0] act;
    logic [7:0]  b;
    logic        abort;
    int          s;
    forever begin
      @(negedge clock);
      if (reset) begin
        exp_q.delete();
        continue;
      end
      if (txd4 == 1'b0) begin
        s = cyc;
        act = '0;
        abort = 1'b0;
        for (int k = 0; k < 40; k++) begin
          if (k > 0) @(negedge clock);
          if (reset) begin
            abort = 1'b1;
            break;
          end
          act[k] = txd4;
        end
        if (abort) begin
          exp_q.delete();
          continue;
        end
        start_q.push_back(s);
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", {24'd0, act}, 64'd0);
        end else begin
          b = exp_q.pop_front();
          chk("frame", {24'd0, act}, {24'd0, frame4(b)});
        end
      end
    end
  end

  // Offer a byte to dut4, holding it until accepted; returns the accepting edge.
  task automatic put4(input logic [7:0] b, output int edge_n);
    int n;
    n = 0;
    @(negedge clock);
    tx_valid4 = 1'b1;
    tx_data4  = b;
    while (!tx_ready4 && n < 300) begin
      @(negedge clock);
      n++;
    end
    edge_n = cyc + 1;
    if (tx_ready4) exp_q.push_back(b);
    else chk("write_timeout", 64'd1, 64'd0);
    @(posedge clock);
    #1 tx_valid4 = 1'b0;
  endtask

  task automatic wait_idle4(output int fall);
    int n;
    n = 0;
    @(negedge clock);
    while (busy4 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    fall = cyc;
    if (busy4) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic chk_ready4(input string name, input logic exp);
    @(negedge clock);
    chk(name, {63'd0, tx_ready4}, {63'd0, exp});
  endtask

  initial begin : stim
    int n, n0, n1, fall, zeros, busy_seen;
    int a3, a4, a5;
    logic [9:0] act10, exp10;
    logic [7:0] rb;

    reset = 1'b1;
    tx_valid4 = 1'b0; tx_data4 = 8'h00;
    tx_valid1 = 1'b0; tx_data1 = 8'h00;
    repeat (3) @(negedge clock);
    chk("reset_txd", {63'd0, txd4}, 64'd1);
    chk("reset_busy", {63'd0, busy4}, 64'd0);
    chk("reset_ready", {63'd0, tx_ready4}, 64'd1);
    reset = 1'b0;

    // Single byte while idle: latency, frame shape, busy fall time.
    start_q.delete();
    put4(8'h55, n);
    @(negedge clock);
    chk("latency_txd_still_idle", {63'd0, txd4}, 64'd1);
    chk("busy_after_accept", {63'd0, busy4}, 64'd1);
    wait_idle4(fall);
    chk("busy_fall_offset", 64'(fall - n), 64'd41);
    chk("first_start_offset", (start_q.size() > 0) ? 64'(start_q[0] - n) : 64'hdead, 64'd1);

    // Three back-to-back bytes on consecutive edges.
    start_q.delete();
    put4(8'h01, n0);
    put4(8'h80, n);
    put4(8'hFF, n);
    wait_idle4(fall);
    chk("b2b_frames", 64'(start_q.size()), 64'd3);
    if (start_q.size() == 3) begin
      chk("b2b_start0", 64'(start_q[0] - n0), 64'd1);
      chk("b2b_gap01", 64'(start_q[1] - start_q[0]), 64'd40);
      chk("b2b_gap12", 64'(start_q[2] - start_q[1]), 64'd40);
    end

    // Fill the FIFO while a frame runs; extra bytes wait for free slots.
    put4(8'h10, n);
    put4(8'hA0, a3);
    put4(8'hA1, a3);
    put4(8'hA2, a3);
    put4(8'hA3, a3);
    chk_ready4("full_ready_low", 1'b0);
    put4(8'hA4, a4);
    put4(8'hA5, a5);
    chk("a4_accept_edge", 64'(a4 - n), 64'd42);
    chk("a5_accept_edge", 64'(a5 - n), 64'd82);
    wait_idle4(fall);

    // Push and pop on the same edge at count 2.
    start_q.delete();
    put4(8'h3C, n);
    put4(8'hB0, n1);
    put4(8'hB1, n1);
    while (cyc < n + 39) @(negedge clock);
    put4(8'hB2, n1);
    chk("same_edge_accept", 64'(n1 - n), 64'd41);
    chk_ready4("same_edge_ready", 1'b1);
    put4(8'hB3, n1);
    chk_ready4("count3_ready", 1'b1);
    put4(8'hB4, n1);
    chk_ready4("count4_ready", 1'b0);
    wait_idle4(fall);

    // Reset in the middle of data bit 3 with two bytes queued.
    put4(8'h96, n);
    put4(8'h11, n1);
    put4(8'h22, n1);
    while (cyc < n + 18) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("midframe_reset_txd", {63'd0, txd4}, 64'd1);
    chk("midframe_reset_busy", {63'd0, busy4}, 64'd0);
    chk("midframe_reset_ready", {63'd0, tx_ready4}, 64'd1);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    zeros = 0;
    busy_seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (txd4 == 1'b0) zeros++;
      if (busy4) busy_seen++;
    end
    chk("post_reset_quiet_txd", 64'(zeros), 64'd0);
    chk("post_reset_quiet_busy", 64'(busy_seen), 64'd0);

    // Randomized bytes with random gaps.
    for (int i = 0; i < 10; i++) begin
      rb = 8'($urandom);
      put4(rb, n);
      repeat ($urandom_range(0, 60)) @(negedge clock);
    end
    wait_idle4(fall);
    repeat (2) @(negedge clock);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    // divide_count = 1: one clock per bit.
    @(negedge clock);
    tx_valid1 = 1'b1;
    tx_data1  = 8'hC3;
    n = cyc + 1;
    @(posedge clock);
    #1 tx_valid1 = 1'b0;
    @(negedge clock);
    chk("div1_latency", {63'd0, txd1}, 64'd1);
    exp10 = {1'b1, 8'hC3, 1'b0};
    act10 = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      act10[k] = txd1;
    end
    chk("div1_frame", {54'd0, act10}, {54'd0, exp10});
    chk("div1_busy_last_bit", {63'd0, busy1}, 64'd1);
    @(negedge clock);
    chk("div1_busy_fall", {63'd0, busy1}, 64'd0);
    chk("div1_fall_edge", 64'(cyc - n), 64'd11);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
